tx_segment_scheduler: RTL and testbench

- Upstream sequencer for the Ethernet TX memory controller.
- On each video-frame start, it walks every redundancy pass (txid) and every segment, and generates the per-frame byte counter, the payload window strobe, txid and segment number.
- The memory controller and the frame builder consume these signals to fetch and emit payload bytes.
- Runs entirely in the clk125MHz domain; the start request arrives already synchronised.

---
 rtl/tx_pkg.sv | 19 +
 rtl/tx_position_counter.sv | 44 ++++
 rtl/tx_segment_scheduler.sv | 163 ++++++++++++++++
 tb/tb_tx_segment_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and default constants for the Ethernet TX path.
// The memory controller's start-with-latency arithmetic uses the same defaults.
package tx_pkg;

    typedef enum logic [1:0] {IDLE, FRAME, GAP, DONE} tx_state_e;

    localparam int unsigned CNT_W                  = 12;
    localparam int unsigned DEF_SEGMENT_NUMBER_MAX = 150;
    localparam int unsigned DEF_FRAME_BYTES        = 1490;
    localparam int unsigned DEF_DATA_START         = 43;
    localparam int unsigned DEF_PAYLOAD_BYTES      = 1440;
    localparam int unsigned DEF_IFG_BYTES          = 12;

    // A redundancy of zero still sends one pass.
    function automatic logic [7:0] eff_redundancy(input logic [7:0] red);
        return (red == 8'd0) ? 8'd1 : red;
    endfunction

endpackage

// File: rtl/tx_position_counter.sv
// Nested txid/segment position counter; segment is the inner loop.
// o_last marks the final (txid, segment) pair of a run.
module tx_position_counter
    import tx_pkg::*;
#(
    parameter int unsigned SEGMENT_NUMBER_MAX = DEF_SEGMENT_NUMBER_MAX
) (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_advance,
    input  logic [7:0]  i_red,
    output logic [7:0]  o_txid,
    output logic [15:0] o_segment_num,
    output logic        o_last
);

    localparam logic [15:0] SEG_LAST = 16'(SEGMENT_NUMBER_MAX - 1);

    logic [7:0]  r_txid;
    logic [15:0] r_segment;
    logic        w_seg_wrap;

    assign w_seg_wrap = (r_segment == SEG_LAST);

    always_ff @(posedge clk125MHz) begin
        if (rst || i_clear) begin
            r_txid    <= 8'd1;
            r_segment <= '0;
        end else if (i_advance) begin
            if (w_seg_wrap) begin
                r_segment <= '0;
                r_txid    <= r_txid + 8'd1;
            end else begin
                r_segment <= r_segment + 16'd1;
            end
        end
    end

    assign o_txid        = r_txid;
    assign o_segment_num = r_segment;
    assign o_last        = w_seg_wrap && (r_txid == i_red);

endmodule

// File: rtl/tx_segment_scheduler.sv
// Walks every redundancy pass and segment of a video frame, producing the TX byte slot timing.
// Optional TX_SCHED_PAUSE_EN adds i_pause, which can stretch the final cycle of an inter-frame gap.
module tx_segment_scheduler
    import tx_pkg::*;
#(
    parameter int unsigned SEGMENT_NUMBER_MAX = DEF_SEGMENT_NUMBER_MAX,
    parameter int unsigned FRAME_BYTES        = DEF_FRAME_BYTES,
    parameter int unsigned DATA_START         = DEF_DATA_START,
    parameter int unsigned PAYLOAD_BYTES      = DEF_PAYLOAD_BYTES,
    parameter int unsigned IFG_BYTES          = DEF_IFG_BYTES
) (
    input  logic             clk125MHz,
    input  logic             rst,
    input  logic             i_start,
    input  logic [7:0]       i_redundancy,
`ifdef TX_SCHED_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_txid,
    output logic [15:0]      o_segment_num,
    output logic [CNT_W-1:0] o_byte_data_counter,
    output logic             o_data_user,
    output logic             o_frame_active
);

    if (FRAME_BYTES > 4095 || FRAME_BYTES < 1) begin : g_chk_frame
        $error("FRAME_BYTES must be within 1..4095");
    end
    if (DATA_START + PAYLOAD_BYTES > FRAME_BYTES) begin : g_chk_payload
        $error("DATA_START + PAYLOAD_BYTES exceeds FRAME_BYTES");
    end
    if (IFG_BYTES < 1 || IFG_BYTES > 4096) begin : g_chk_ifg
        $error("IFG_BYTES must be within 1..4096");
    end
    if (SEGMENT_NUMBER_MAX < 1 || SEGMENT_NUMBER_MAX > 65536) begin : g_chk_seg
        $error("SEGMENT_NUMBER_MAX must be within 1..65536");
    end

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(DATA_START);
    localparam logic [CNT_W-1:0] DATA_END   = CNT_W'(DATA_START + PAYLOAD_BYTES);

    tx_state_e        r_state, w_state_next;
    logic [CNT_W-1:0] r_counter, w_counter_next;
    logic [7:0]       r_red;
    logic             r_data_user;
    logic             w_pause;
    logic             w_start_acc;
    logic             w_frame_end;
    logic             w_gap_end;
    logic             w_pos_last;
    logic             w_pos_clear;
    logic             w_pos_advance;

`ifdef TX_SCHED_PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_start_acc   = (r_state == IDLE) && i_start;
    assign w_frame_end   = (r_state == FRAME) && (r_counter == FRAME_LAST);
    // Pause only holds the last gap cycle, so a running frame is never touched.
    assign w_gap_end     = (r_state == GAP) && (r_counter == GAP_LAST) && !w_pause;
    assign w_pos_clear   = w_start_acc || (w_gap_end && w_pos_last);
    assign w_pos_advance = w_gap_end && !w_pos_last;

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        case (r_state)
            IDLE: begin
                w_counter_next = '0;
                if (i_start) begin
                    w_state_next = FRAME;
                end
            end
            FRAME: begin
                if (w_frame_end) begin
                    w_state_next   = GAP;
                    w_counter_next = '0;
                end else begin
                    w_counter_next = r_counter + 1'b1;
                end
            end
            GAP: begin
                if (w_gap_end) begin
                    w_state_next   = w_pos_last ? DONE : FRAME;
                    w_counter_next = '0;
                end else if (r_counter != GAP_LAST) begin
                    w_counter_next = r_counter + 1'b1;
                end
            end
            DONE: begin
                w_state_next   = IDLE;
                w_counter_next = '0;
            end
            default: begin
                w_state_next   = IDLE;
                w_counter_next = '0;
            end
        endcase
    end

    always_comb begin
        o_busy         = 1'b0;
        o_done         = 1'b0;
        o_frame_active = 1'b0;
        case (r_state)
            FRAME: begin
                o_busy         = 1'b1;
                o_frame_active = 1'b1;
            end
            GAP:     o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // data_user is computed from the next counter so it lands in the same cycle as that count.
    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            r_counter   <= '0;
            r_red       <= 8'd1;
            r_data_user <= 1'b0;
        end else begin
            r_counter   <= w_counter_next;
            r_data_user <= (w_state_next == FRAME) && (w_counter_next >= DATA_FIRST)
                           && (w_counter_next < DATA_END);
            if (w_start_acc) begin
                r_red <= eff_redundancy(i_redundancy);
            end
        end
    end

    tx_position_counter #(
        .SEGMENT_NUMBER_MAX (SEGMENT_NUMBER_MAX)
    ) u_pos (
        .clk125MHz     (clk125MHz),
        .rst           (rst),
        .i_clear       (w_pos_clear),
        .i_advance     (w_pos_advance),
        .i_red         (r_red),
        .o_txid        (o_txid),
        .o_segment_num (o_segment_num),
        .o_last        (w_pos_last)
    );

    assign o_byte_data_counter = r_counter;
    assign o_data_user         = r_data_user;

endmodule

// File: tb/tb_tx_segment_scheduler.sv
// Scoreboard bench for tx_segment_scheduler: stimulus queues expected frames and done times,
// a negedge monitor pops and compares them. Exercises i_pause when TX_SCHED_PAUSE_EN is defined.
module tb_tx_segment_scheduler;

    localparam int SEG = 3;
    localparam int FB  = 60;
    localparam int DS  = 10;
    localparam int PB  = 20;
    localparam int IFG = 4;

    typedef struct {
        int txid;
        int seg;
        int gap_before;
    } frame_t;

    typedef struct {
        int start_cyc;
        int done_cyc;
    } run_t;

    logic        clk125MHz = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_redundancy = 8'd0;
    logic        i_pause = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_txid;
    logic [15:0] o_segment_num;
    logic [11:0] o_byte_data_counter;
    logic        o_data_user;
    logic        o_frame_active;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    frame_t exp_frames[$];
    run_t   exp_runs[$];

    always #4 clk125MHz = ~clk125MHz;
    always @(posedge clk125MHz) cyc <= cyc + 1;

    tx_segment_scheduler #(
        .SEGMENT_NUMBER_MAX (SEG),
        .FRAME_BYTES        (FB),
        .DATA_START         (DS),
        .PAYLOAD_BYTES      (PB),
        .IFG_BYTES          (IFG)
    ) dut (
        .clk125MHz           (clk125MHz),
        .rst                 (rst),
        .i_start             (i_start),
        .i_redundancy        (i_redundancy),
`ifdef TX_SCHED_PAUSE_EN
        .i_pause             (i_pause),
`endif
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_txid              (o_txid),
        .o_segment_num       (o_segment_num),
        .o_byte_data_counter (o_byte_data_counter),
        .o_data_user         (o_data_user),
        .o_frame_active      (o_frame_active)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_txid"}, int'(o_txid), 1);
        check({tag, "_seg"}, int'(o_segment_num), 0);
        check({tag, "_counter"}, int'(o_byte_data_counter), 0);
        check({tag, "_data_user"}, int'(o_data_user), 0);
        check({tag, "_frame_active"}, int'(o_frame_active), 0);
    endtask

    // Reference: one frame per (pass, segment), FB+IFG cycles each, done right after the last gap.
    task automatic start_run(input logic [7:0] red, input int extra, input int pause_idx);
        int passes;
        int idx;
        run_t r;
        passes = (red == 8'd0) ? 1 : int'(red);
        idx = 0;
        for (int t = 1; t <= passes; t++) begin
            for (int s = 0; s < SEG; s++) begin
                frame_t f;
                f.txid = t;
                f.seg  = s;
                f.gap_before = (idx == 0) ? -1 : ((idx == pause_idx) ? IFG + extra : IFG);
                exp_frames.push_back(f);
                idx++;
            end
        end
        r.start_cyc = cyc;
        r.done_cyc  = cyc + 1 + passes * SEG * (FB + IFG) + extra;
        exp_runs.push_back(r);
        i_redundancy = red;
        i_start = 1'b1;
        @(posedge clk125MHz);
        #2;
        i_start = 1'b0;
    endtask

    task automatic wait_pos(input int t, input int s, input int cnt, input logic fa,
                            input string name);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 3000) begin
            @(negedge clk125MHz);
            if (o_busy && o_frame_active == fa && int'(o_txid) == t &&
                int'(o_segment_num) == s && int'(o_byte_data_counter) == cnt) hit = 1;
            n++;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: position (%0d,%0d,%0d) not reached, got 0 expected 1",
                     name, t, s, cnt);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_runs.size() != 0 && n < 3000) begin
            @(posedge clk125MHz);
            #2;
            i_redundancy = 8'($urandom);
            n++;
        end
        check({name, "_run_finished"}, exp_runs.size(), 0);
        check({name, "_frames_consumed"}, exp_frames.size(), 0);
        exp_runs.delete();
        exp_frames.delete();
    endtask

    // Monitor
    initial begin
        bit prev_fa;
        int frame_len;
        int gap_len;
        int cur_txid;
        int cur_seg;
        frame_t ef;
        run_t er;
        prev_fa = 0;
        frame_len = 0;
        gap_len = 0;
        cur_txid = 0;
        cur_seg = 0;
        forever begin
            @(negedge clk125MHz);
            if (rst) begin
                prev_fa = 0;
                gap_len = 0;
                frame_len = 0;
            end else begin
                if (o_frame_active) begin
                    if (!prev_fa) begin
                        if (exp_frames.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            ef = exp_frames.pop_front();
                            check("frame_txid", int'(o_txid), ef.txid);
                            check("frame_seg", int'(o_segment_num), ef.seg);
                            if (ef.gap_before >= 0) check("gap_len", gap_len, ef.gap_before);
                        end
                        frame_len = 0;
                        cur_txid = int'(o_txid);
                        cur_seg = int'(o_segment_num);
                    end
                    check("frame_counter", int'(o_byte_data_counter), frame_len);
                    check("data_user", int'(o_data_user),
                          (frame_len >= DS && frame_len < DS + PB) ? 1 : 0);
                    check("txid_stable", int'(o_txid), cur_txid);
                    check("seg_stable", int'(o_segment_num), cur_seg);
                    frame_len++;
                end else begin
                    if (prev_fa) begin
                        check("frame_len", frame_len, FB);
                        gap_len = 0;
                    end
                    check("data_user_idle", int'(o_data_user), 0);
                    if (o_busy) begin
                        check("gap_counter", int'(o_byte_data_counter),
                              (gap_len < IFG - 1) ? gap_len : IFG - 1);
                        gap_len++;
                    end
                end
                if (exp_runs.size() != 0) begin
                    er = exp_runs[0];
                    if (cyc > er.start_cyc && cyc < er.done_cyc) check("busy_run", int'(o_busy), 1);
                    if (cyc > er.done_cyc) begin
                        check("done_missing", 0, 1);
                        void'(exp_runs.pop_front());
                    end
                end
                if (o_done) begin
                    if (exp_runs.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        er = exp_runs.pop_front();
                        check("done_cycle", cyc, er.done_cyc);
                    end
                    check("done_busy", int'(o_busy), 0);
                    check("done_txid", int'(o_txid), 1);
                    check("done_seg", int'(o_segment_num), 0);
                end
                prev_fa = o_frame_active;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 0);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk125MHz);
        @(negedge clk125MHz);
        check_reset("reset");
        @(posedge clk125MHz);
        #2;
        rst = 1'b0;

        // Two passes, full order, gap and done timing.
        repeat (2) @(posedge clk125MHz);
        #2;
        start_run(8'd2, 0, -1);
        wait_idle("red2");

        // Zero redundancy behaves as one pass.
        repeat (3) @(posedge clk125MHz);
        #2;
        start_run(8'd0, 0, -1);
        wait_idle("red0");

        // Start while busy is ignored.
        @(posedge clk125MHz);
        #2;
        start_run(8'd2, 0, -1);
        wait_pos(1, 1, 5, 1'b1, "restart_pos");
        @(posedge clk125MHz);
        #2;
        i_start = 1'b1;
        i_redundancy = 8'd5;
        @(posedge clk125MHz);
        #2;
        i_start = 1'b0;
        wait_idle("restart");

        // Reset mid-frame, then a fresh run starts at (1,0).
        @(posedge clk125MHz);
        #2;
        start_run(8'd2, 0, -1);
        wait_pos(2, 0, 24, 1'b1, "rst_pos");
        @(posedge clk125MHz);
        #2;
        rst = 1'b1;
        @(negedge clk125MHz);
        @(negedge clk125MHz);
        check_reset("midrst");
        exp_frames.delete();
        exp_runs.delete();
        @(posedge clk125MHz);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk125MHz);
        #2;
        start_run(8'd1, 0, -1);
        wait_idle("after_rst");

`ifdef TX_SCHED_PAUSE_EN
        // Pause on the last gap cycle stretches that gap; pause inside a frame changes nothing.
        @(posedge clk125MHz);
        #2;
        start_run(8'd2, 10, 1);
        wait_pos(1, 0, 2, 1'b0, "pause_gap_pos");
        @(posedge clk125MHz);
        #2;
        i_pause = 1'b1;
        repeat (10) @(posedge clk125MHz);
        #2;
        i_pause = 1'b0;
        wait_pos(1, 2, 20, 1'b1, "pause_frame_pos");
        @(posedge clk125MHz);
        #2;
        i_pause = 1'b1;
        wait_pos(1, 2, 50, 1'b1, "pause_frame_end");
        @(posedge clk125MHz);
        #2;
        i_pause = 1'b0;
        wait_idle("pause");
`endif

        // Randomised runs with redundancy scrambled while busy.
        for (int k = 0; k < 4; k++) begin
            int idle;
            logic [7:0] red;
            idle = $urandom_range(1, 6);
            red = 8'($urandom_range(0, 3));
            repeat (idle) @(posedge clk125MHz);
            #2;
            start_run(red, 0, -1);
            wait_idle("random");
        end

        repeat (4) @(posedge clk125MHz);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
